fsk_demodulator: RTL and testbench

FSK_DEMODULATOR -- requirements
Module: fsk_demodulator

---
 rtl/fsk_demodulator.sv | 135 +++++++++++++
 tb/tb_fsk_demodulator.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/fsk_demodulator.sv
// Non-coherent FSK demodulator: cross-product discriminator, integrate-and-dump
// symbol decision, preamble search with timing slip, and weak-symbol loss of lock.
module fsk_demodulator #(
   parameter int SIN_W    = 8,
   parameter int SPS      = 4,
   parameter int PRE_LEN  = 8,
   parameter int THRESH   = 1024,
   parameter int LOSS_CNT = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    enable,
   input  logic                    sample_valid,
   input  logic signed [SIN_W-1:0] fsk_i,
   input  logic signed [SIN_W-1:0] fsk_q,
   output logic                    bit_out,
   output logic                    bit_valid,
   output logic                    preamble_det,
   output logic                    locked
);
   localparam int PW = 2*SIN_W;
   localparam int DW = PW + 1;
   localparam int CW = $clog2(SPS);
   localparam int AW = DW + CW;
   localparam int FW = $clog2(PRE_LEN + 1);
   localparam int WW = $clog2(LOSS_CNT + 1);
   localparam logic [AW-1:0] TH = AW'(THRESH);

   function automatic logic [PRE_LEN-1:0] alt_pat();
      logic [PRE_LEN-1:0] p;
      for (int k = 0; k < PRE_LEN; k++) p[k] = k[0];
      return p;
   endfunction
   localparam logic [PRE_LEN-1:0] ALT = alt_pat();

   typedef enum logic {SEARCH, LOCKED} state_t;
   state_t r_state, w_state_nxt;

   logic signed [SIN_W-1:0] r_i_prev, r_q_prev;
   logic signed [AW-1:0]    r_acc;
   logic [CW-1:0]           r_cnt;
   logic [PRE_LEN-1:0]      r_hist;
   logic [FW-1:0]           r_fill, r_sym;
   logic                    r_slip;
   logic [WW-1:0]           r_weak;
   logic                    r_bit, r_bit_vld, r_pre;

   logic signed [PW-1:0] w_ip, w_qp, w_ic, w_qc, w_a, w_b;
   logic signed [DW-1:0] w_d;
   logic signed [AW-1:0] w_sum;
   logic [AW-1:0]        w_abs;
   logic [PRE_LEN-1:0]   w_hist_nxt;
   logic w_acc_en, w_close, w_bit, w_weak, w_det, w_loss, w_clear;

   assign w_ip  = {{SIN_W{r_i_prev[SIN_W-1]}}, r_i_prev};
   assign w_qp  = {{SIN_W{r_q_prev[SIN_W-1]}}, r_q_prev};
   assign w_ic  = {{SIN_W{fsk_i[SIN_W-1]}}, fsk_i};
   assign w_qc  = {{SIN_W{fsk_q[SIN_W-1]}}, fsk_q};
   assign w_a   = w_ip * w_qc;
   assign w_b   = w_qp * w_ic;
   assign w_d   = {w_a[PW-1], w_a} - {w_b[PW-1], w_b};
   assign w_sum = r_acc + {{CW{w_d[DW-1]}}, w_d};
   assign w_abs = w_sum[AW-1] ? -w_sum : w_sum;

   // A pending slip holds the counter, so that sample cannot close a symbol
   assign w_acc_en   = enable && sample_valid;
   assign w_close    = w_acc_en && !r_slip && (r_cnt == CW'(SPS-1));
   assign w_bit      = !w_sum[AW-1];
   assign w_weak     = w_abs < TH;
   assign w_hist_nxt = (r_hist << 1) | {{(PRE_LEN-1){1'b0}}, w_bit};
   assign w_det      = (r_fill >= FW'(PRE_LEN-1)) && (w_hist_nxt == ALT || w_hist_nxt == ~ALT);
   assign w_loss     = (r_state == LOCKED) && w_close && w_weak && (r_weak == WW'(LOSS_CNT-1));
   assign w_clear    = !enable || w_loss;

   always_comb begin
      w_state_nxt = r_state;
      if (w_clear)
         w_state_nxt = SEARCH;
      else if (r_state == SEARCH && w_close && w_det)
         w_state_nxt = LOCKED;
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= SEARCH;
      else     r_state <= w_state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst || w_clear) begin
         r_i_prev <= '0; r_q_prev <= '0; r_acc <= '0; r_cnt <= '0;
         r_hist <= '0; r_fill <= '0; r_sym <= '0; r_slip <= 1'b0; r_weak <= '0;
         r_bit <= 1'b0; r_bit_vld <= 1'b0; r_pre <= 1'b0;
      end else begin
         r_bit_vld <= 1'b0;
         r_pre     <= 1'b0;
         if (w_acc_en) begin
            r_i_prev <= fsk_i;
            r_q_prev <= fsk_q;
            if (r_slip) begin
               r_slip <= 1'b0;
               r_acc  <= w_sum;
            end else if (w_close) begin
               r_acc <= '0;
               r_cnt <= '0;
               r_bit <= w_bit;
               if (r_state == SEARCH) begin
                  r_hist <= w_hist_nxt;
                  if (r_fill != FW'(PRE_LEN)) r_fill <= r_fill + 1'b1;
                  if (w_det) begin
                     r_pre  <= 1'b1;
                     r_sym  <= '0;
                     r_weak <= '0;
                  end else if (r_sym == FW'(PRE_LEN-1)) begin
                     r_sym  <= '0;
                     r_slip <= 1'b1;
                  end else begin
                     r_sym <= r_sym + 1'b1;
                  end
               end else begin
                  r_bit_vld <= 1'b1;
                  r_weak    <= w_weak ? r_weak + 1'b1 : '0;
               end
            end else begin
               r_acc <= w_sum;
               r_cnt <= r_cnt + 1'b1;
            end
         end
      end
   end

   assign bit_out      = r_bit;
   assign bit_valid    = r_bit_vld;
   assign preamble_det = r_pre;
   assign locked       = (r_state == LOCKED);
endmodule

// File: tb/tb_fsk_demodulator.sv
// Directed bench for fsk_demodulator: continuous-phase tones, lock, slip,
// threshold boundary, loss of lock, reset/enable clearing.
module tb_fsk_demodulator;
   localparam int SPS = 4;

   logic clk = 1'b0;
   logic rst, enable, sample_valid;
   logic signed [7:0] fsk_i, fsk_q;
   logic bit_out, bit_valid, preamble_det, locked;

   int n_cmp = 0, n_err = 0;
   int n_bv = 0, n_pre = 0, cyc = 0, bv_cyc = 0, bv_prev = 0;
   int ph = 0, lock_at;
   logic chk_on = 1'b0;

   fsk_demodulator dut (
      .clk(clk), .rst(rst), .enable(enable), .sample_valid(sample_valid),
      .fsk_i(fsk_i), .fsk_q(fsk_q), .bit_out(bit_out), .bit_valid(bit_valid),
      .preamble_det(preamble_det), .locked(locked)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic signed [7:0] iv(input int p, input int a);
      case (p)
         0:       return 8'(a);
         2:       return 8'(-a);
         default: return 8'sd0;
      endcase
   endfunction

   function automatic logic signed [7:0] qv(input int p, input int a);
      case (p)
         1:       return 8'(a);
         3:       return 8'(-a);
         default: return 8'sd0;
      endcase
   endfunction

   // Drive one cycle; the tone tag is the symbol the fed sample belongs to
   task automatic feed(input logic signed [7:0] i, input logic signed [7:0] q,
                       input logic v, input logic tone);
      fsk_i = i; fsk_q = q; sample_valid = v;
      @(posedge clk); #1;
      cyc++;
      if (bit_valid) begin
         n_bv++;
         bv_prev = bv_cyc;
         bv_cyc  = cyc;
         if (chk_on) check("bit", int'(bit_out), int'(tone));
      end
      if (preamble_det) n_pre++;
   endtask

   task automatic sym(input logic b, input int amp, input int first, input logic gap);
      for (int s = first; s < SPS; s++) begin
         ph = b ? (ph + 1) % 4 : (ph + 3) % 4;
         feed(iv(ph, amp), qv(ph, amp), 1'b1, b);
         if (gap) feed(8'sd0, 8'sd0, 1'b0, b);
      end
   endtask

   task automatic zsym();
      for (int s = 0; s < SPS; s++) feed(8'sd0, 8'sd0, 1'b1, 1'b0);
   endtask

   task automatic do_reset();
      rst = 1'b1; sample_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; enable = 1'b1; sample_valid = 1'b0; fsk_i = '0; fsk_q = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_bit_out", int'(bit_out), 0);
      check("rst_bit_valid", int'(bit_valid), 0);
      check("rst_preamble", int'(preamble_det), 0);
      check("rst_locked", int'(locked), 0);
      rst = 1'b0;

      // steady +1 tone never forms a preamble
      for (int k = 0; k < 12; k++) sym(1'b1, 127, 0, 1'b0);
      check("v1_no_bv", n_bv, 0);
      check("v1_no_pre", n_pre, 0);
      check("v1_unlocked", int'(locked), 0);

      // aligned alternating preamble locks on the 8th closing sample
      do_reset();
      chk_on = 1'b1;
      for (int k = 0; k < 8; k++) sym(k % 2 == 0, 127, 0, 1'b0);
      check("v2_pre_pulse", int'(preamble_det), 1);
      check("v2_locked", int'(locked), 1);
      check("v2_no_bv_on_lock", int'(bit_valid), 0);
      check("v2_pre_once", n_pre, 1);
      n_bv = 0;
      for (int k = 0; k < 4; k++) sym(k % 2 == 0, 127, 0, 1'b0);
      check("v2_bv_cnt", n_bv, 4);
      check("v2_pre_cleared", int'(preamble_det), 0);

      // half-rate sample_valid: one decision every 8 clocks
      n_bv = 0;
      sym(1'b1, 127, 0, 1'b1);
      sym(1'b0, 127, 0, 1'b1);
      check("v5_gap_a", bv_cyc - bv_prev, 8);
      sym(1'b1, 127, 0, 1'b1);
      check("v5_gap_b", bv_cyc - bv_prev, 8);
      check("v5_bv_cnt", n_bv, 3);

      // amplitude 16 gives |acc| = 1024 exactly (strong); 15 gives 900/915 (weak)
      n_bv = 0;
      for (int k = 0; k < 5; k++) sym(k % 2 == 1, 16, 0, 1'b0);
      check("thr16_locked", int'(locked), 1);
      check("thr16_bv_cnt", n_bv, 5);
      for (int k = 0; k < 3; k++) sym(k % 2 == 0, 15, 0, 1'b0);
      check("thr15_locked_3", int'(locked), 1);
      sym(1'b1, 15, 0, 1'b0);
      check("thr15_loss", int'(locked), 0);
      check("thr15_no_bv", int'(bit_valid), 0);

      // relock, then all-zero input drops lock on the 4th weak symbol
      for (int k = 0; k < 8; k++) sym(k % 2 == 0, 127, 0, 1'b0);
      check("v4_relock", int'(locked), 1);
      chk_on = 1'b0;
      for (int k = 0; k < 3; k++) zsym();
      check("v4_locked_3", int'(locked), 1);
      zsym();
      check("v4_loss", int'(locked), 0);
      check("v4_no_bv", int'(bit_valid), 0);

      // reset mid-symbol clears lock and history
      chk_on = 1'b1;
      for (int k = 0; k < 8; k++) sym(k % 2 == 0, 127, 0, 1'b0);
      check("v6_lock", int'(locked), 1);
      sym(1'b1, 127, 2, 1'b0);
      rst = 1'b1;
      feed(iv(ph, 127), qv(ph, 127), 1'b1, 1'b1);
      rst = 1'b0;
      check("v6_rst_locked", int'(locked), 0);
      check("v6_rst_bv", int'(bit_valid), 0);
      check("v6_rst_bit_out", int'(bit_out), 0);
      n_bv = 0;
      for (int k = 0; k < 8; k++) begin
         sym(k % 2 == 0, 127, 0, 1'b0);
         if (k == 3) check("v6_rst_no_relock", int'(locked), 0);
      end
      check("v6_rst_no_bv", n_bv, 0);
      check("v6_fresh_relock", int'(locked), 1);

      // one cycle of enable low behaves like loss of lock
      sym(1'b1, 127, 2, 1'b0);
      enable = 1'b0;
      feed(iv(ph, 127), qv(ph, 127), 1'b1, 1'b1);
      check("v6_en_locked", int'(locked), 0);
      check("v6_en_bv", int'(bit_valid), 0);
      check("v6_en_pre", int'(preamble_det), 0);
      enable = 1'b1;
      n_bv = 0;
      for (int k = 0; k < 4; k++) sym(k % 2 == 0, 127, 0, 1'b0);
      check("v6_en_no_relock", int'(locked), 0);
      check("v6_en_no_bv", n_bv, 0);

      // preamble offset by 2 samples: slips must find a lockable phase
      do_reset();
      n_pre = 0; n_bv = 0; lock_at = 0;
      sym(1'b1, 127, 2, 1'b0);
      for (int k = 1; k < 24; k++) begin
         sym(k % 2 == 0, 127, 0, 1'b0);
         if (locked && lock_at == 0) lock_at = k;
      end
      for (int k = 0; k < 8; k++) sym(k inside {0, 1, 4, 5, 6}, 127, 0, 1'b0);
      check("v3_locked", int'(locked), 1);
      check("v3_pre_once", n_pre, 1);
      check("v3_lock_in_time", int'(lock_at > 0 && lock_at <= SPS * 8), 1);
      check("v3_bits_seen", int'(n_bv >= 8), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
